elevator_call_scheduler: RTL
============================

ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200: cycles allowed in WAIT before a dispatch is abandoned (range 2..255).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port call_btn  in  4  per-floor call buttons, bit i = floor i, level-sampled each cycle.
REQ-005 SHALL have port current_floor  in  2  floor reported by the downstream elevator FSM.
REQ-006 SHALL have port moving  in  1  elevator FSM is travelling.
REQ-007 SHALL have port door_open  in  1  elevator FSM door is open.
REQ-008 SHALL have port emergency_call  in  1  elevator FSM is in emergency; dispatch suspended.
REQ-009 SHALL have port floor_request  out  2  target floor presented to the elevator FSM.
REQ-010 SHALL have port request_valid  out  1  one-cycle dispatch strobe qualifying floor_request.
REQ-011 SHALL have port pending  out  4  registered outstanding-call mask.
REQ-012 SHALL have port dir_up  out  1  current sweep direction, 1 = up.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port timeout_err  out  1  one-cycle pulse when a dispatch is abandoned.

Function
REQ-015 SHALL set pending[i] the cycle after call_btn[i]=1; bits stay set until serviced.
REQ-016 SHALL clear pending[i] the cycle after door_open=1 with current_floor=i; clear wins over a simultaneous set of the same bit.
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, DOOR, HALT; exactly one active.
REQ-018 IDLE -> ISSUE when pending!=0, moving=0, door_open=0, emergency_call=0; target latched on that edge.
REQ-019 Target selection (SCAN): pending[current_floor] first; else if dir_up, lowest pending floor above current_floor; if none, dir_up<=0 and highest pending below; mirror rule when dir_up=0.
REQ-020 ISSUE: request_valid=1 and floor_request=target for exactly one cycle, then WAIT; floor_request holds target until next ISSUE.
REQ-021 WAIT: counter increments per cycle; door_open=1 with current_floor=target -> DOOR.
REQ-022 WAIT: counter reaching TIMEOUT without arrival -> IDLE, timeout_err pulses one cycle, pending unchanged (call re-dispatched).
REQ-023 DOOR -> IDLE when door_open returns to 0.
REQ-024 emergency_call=1 in any state -> HALT next cycle; request_valid forced 0; pending keeps latching calls.
REQ-025 HALT -> IDLE the cycle after emergency_call=0; WAIT counter cleared.
REQ-026 Call for current floor while idle SHALL be dispatched normally (target=current_floor); no direction change.
REQ-027 request_valid SHALL never assert on consecutive cycles, nor while moving=1 or door_open=1 at entry to ISSUE.
REQ-028 Latency: pending bit visible at cycle t with FSM idle -> request_valid high at t+1.

Reset
REQ-029 While reset=0: state IDLE, pending=0, floor_request=0, request_valid=0, dir_up=1, busy=0, timeout_err=0, counter=0, asynchronously.
REQ-030 Reset asserted mid-dispatch SHALL drop all pending calls; no request_valid on the first cycle after release.

Verification
REQ-031 current_floor=0, idle, call_btn=4'b0100 one cycle -> pending=4'b0100 next cycle, request_valid one cycle with floor_request=2, busy=1.
REQ-032 dir_up=1, current_floor=1, pending=4'b1001 -> floor_request=3 first; after arrival at 3 and door close, dir_up=0, floor_request=0.
REQ-033 door_open=1, current_floor=2, call_btn[2]=1 same cycle -> pending[2]=0.
REQ-034 TIMEOUT=20, dispatch to 3 with no door_open -> timeout_err pulse 20 cycles after ISSUE, then request_valid re-issued for floor 3.
REQ-035 emergency_call=1 during WAIT -> HALT, request_valid stays 0, call_btn[1] latched; emergency_call=0 -> IDLE, then dispatch.
REQ-036 reset=0 asynchronously during WAIT with pending=4'b1010 -> all outputs reset values immediately, pending=0.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
// SCAN-style call scheduler: latches floor calls, picks the next target in the
// current sweep direction and hands it to the elevator FSM with a one-cycle strobe.
module elevator_call_scheduler #(
  parameter int TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_btn,
  input  logic [1:0] current_floor,
  input  logic       moving,
  input  logic       door_open,
  input  logic       emergency_call,
  output logic [1:0] floor_request,
  output logic       request_valid,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DOOR,
    S_HALT
  } state_t;

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [3:0] clr_mask;
  logic [2:0] scan_sel;

  // Returns {new_dir_up, target_floor}; only meaningful when pend != 0.
  function automatic logic [2:0] scan_pick(input logic [3:0] pend,
                                           input logic [1:0] cf,
                                           input logic       up);
    logic [1:0] lo_above = 2'd0;
    logic [1:0] hi_below = 2'd0;
    logic       has_above = 1'b0;
    logic       has_below = 1'b0;
    logic [2:0] sel;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i] && (i > int'(cf))) begin
        lo_above  = 2'(i);
        has_above = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && (i < int'(cf))) begin
        hi_below  = 2'(i);
        has_below = 1'b1;
      end
    end
    if (pend[cf])
      sel = {up, cf};
    else if (up)
      sel = has_above ? {1'b1, lo_above} : {1'b0, hi_below};
    else
      sel = has_below ? {1'b0, hi_below} : {1'b1, lo_above};
    return sel;
  endfunction

  assign clr_mask = door_open ? (4'b0001 << current_floor) : 4'b0000;
  assign scan_sel = scan_pick(pending, current_floor, dir_up);

  // Call latch: service at the open door beats a new press of the same floor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pending <= 4'b0000;
    else
      pending <= (pending | call_btn) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      floor_request <= 2'd0;
      request_valid <= 1'b0;
      dir_up        <= 1'b1;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      wait_cnt      <= 8'd0;
    end else begin
      request_valid <= 1'b0;
      timeout_err   <= 1'b0;
      if (emergency_call) begin
        state <= S_HALT;
        busy  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if ((pending != 4'b0000) && !moving && !door_open) begin
              state         <= S_ISSUE;
              busy          <= 1'b1;
              floor_request <= scan_sel[1:0];
              dir_up        <= scan_sel[2];
              request_valid <= 1'b1;
            end
          end
          S_ISSUE: begin
            // The issue cycle itself counts toward the arrival budget.
            state    <= S_WAIT;
            wait_cnt <= 8'd1;
          end
          S_WAIT: begin
            if (door_open && (current_floor == floor_request)) begin
              state <= S_DOOR;
            end else if (({1'b0, wait_cnt} + 9'd1) == TO_LIM) begin
              state       <= S_IDLE;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
              wait_cnt    <= 8'd0;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          S_DOOR: begin
            if (!door_open) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_HALT: begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            wait_cnt <= 8'd0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
